alu_div_unit: RTL and testbench

//  Iterative RV32M divide/remainder unit in the EX stage; responder to the EX ALU operand dispatcher.

---
 rtl/alu_div_unit.sv | 127 ++++++++++++
 tb/tb_alu_div_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_unit.sv
// Iterative RV32M divide/remainder unit: restoring radix-2, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved when the operation is accepted.
module alu_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] div_s1,
  input  logic [WIDTH-1:0] div_s2,
  input  logic             div_flush,
  output logic             div_busy,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] div_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q, neg_r, is_rem;

  logic             sgn, a_neg, b_neg, div0, ovf, accept;
  logic [WIDTH-1:0] a_mag, b_mag, special_res, q_fix, r_fix;
  logic [WIDTH+1:0] shifted, diff;

  assign sgn    = ~div_op[0];
  assign a_neg  = sgn & div_s1[WIDTH-1];
  assign b_neg  = sgn & div_s2[WIDTH-1];
  assign a_mag  = a_neg ? -div_s1 : div_s1;
  assign b_mag  = b_neg ? -div_s2 : div_s2;
  assign div0   = (div_s2 == '0);
  assign ovf    = sgn & (div_s1 == MIN_VAL) & (div_s2 == '1);
  assign accept = (state == S_IDLE) & div_start & ~div_flush;

  always_comb begin
    special_res = '0;
    if (div0) special_res = div_op[1] ? div_s1 : '1;
    else      special_res = div_op[1] ? '0 : MIN_VAL;
  end

  // Trial subtraction on the shifted partial remainder; top bit set means it went negative.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvsr};

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  assign div_busy  = (state != S_IDLE);
  assign div_stall = accept | (state == S_CALC) | (state == S_FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      is_rem     <= 1'b0;
      div_done   <= 1'b0;
      div_result <= '0;
    end else begin
      div_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_rem <= div_op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            rem    <= '0;
            quo    <= a_mag;
            dvsr   <= b_mag;
            cnt    <= '0;
            if (div0 | ovf) begin
              div_result <= special_res;
              div_done   <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (div_flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            if (!diff[WIDTH+1]) begin
              rem <= diff[WIDTH:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            if (cnt == CNT_W'(WIDTH-1)) begin
              cnt   <= '0;
              state <= S_FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FIX: begin
          if (div_flush) begin
            state <= S_IDLE;
          end else begin
            div_result <= is_rem ? r_fix : q_fix;
            div_done   <= 1'b1;
            state      <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_unit.sv
// Self-checking bench for alu_div_unit: directed RV32M corner cases, randomized ops
// against an arithmetic reference model, flush/reset/back-to-back protocol scenarios.
module tb_alu_div_unit;

  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] div_s1, div_s2;
  logic        div_flush;
  logic        div_busy, div_stall, div_done;
  logic [31:0] div_result;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_result;

  alu_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .div_start(div_start), .div_op(div_op),
    .div_s1(div_s1), .div_s2(div_s2), .div_flush(div_flush),
    .div_busy(div_busy), .div_stall(div_stall), .div_done(div_done),
    .div_result(div_result)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == MIN_VAL && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : MIN_VAL;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0 || (!op[0] && a == MIN_VAL && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issues one op in the current cycle (cycle 0) and waits for done; latency is the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
    step();
    div_start = 1'b1; div_op = op; div_s1 = a; div_s2 = b;
    @(negedge clk);
    stalls = div_stall ? 1 : 0;
    lat = -1;
    res = 'x;
    for (int c = 1; c < 100 && lat < 0; c++) begin
      step();
      div_start = 1'b0;
      @(negedge clk);
      if (div_stall) stalls++;
      if (div_done) begin
        lat = c;
        res = div_result;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; div_start = 1'b0; div_op = 2'b00; div_s1 = '0; div_s2 = '0; div_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", div_busy); end
    tests++; if (div_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", div_done); end
    tests++; if (div_result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h expected 0", div_result); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", div_stall); end
    last_result = 32'd0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [31:0] as  [7] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, MIN_VAL, MIN_VAL};
    logic [31:0] bs  [7] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [7] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, MIN_VAL, 32'd0};
    int          elat[7] = '{34, 34, 34, 1, 1, 1, 1};
    logic [31:0] res;
    int lat, stalls;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, stalls);
      tests++; if (res !== exp[i]) begin fails++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, exp[i]); end
      tests++; if (lat != elat[i]) begin fails++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, elat[i]); end
      tests++; if (stalls != elat[i]) begin fails++; $display("FAIL directed_stall_cycles[%0d]: got %0d expected %0d", i, stalls, elat[i]); end
      last_result = exp[i];
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, stalls, mode;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0: b = 32'd0;
        1: begin a = MIN_VAL; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp = ref_div(op, a, b);
      run_op(op, a, b, res, lat, stalls);
      tests++; if (res !== exp) begin fails++; $display("FAIL random_result op=%0d %h/%h: got %h expected %h", op, a, b, res, exp); end
      tests++; if (lat != ref_lat(op, a, b)) begin fails++; $display("FAIL random_latency op=%0d %h/%h: got %0d expected %0d", op, a, b, lat, ref_lat(op, a, b)); end
      tests++; if (stalls != lat) begin fails++; $display("FAIL random_stall_cycles: got %0d expected %0d", stalls, lat); end
      last_result = exp;
    end
  endtask

  task automatic test_flush();
    int dones = 0;
    int lat = -1;
    logic [31:0] res = 'x;
    step();
    div_start = 1'b1; div_op = 2'b01; div_s1 = 32'd100; div_s2 = 32'd7;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      step();
      div_start = (c == 12);
      div_flush = (c == 10);
      div_s1 = (c == 12) ? 32'd9 : 32'd100;
      div_s2 = (c == 12) ? 32'd3 : 32'd7;
      @(negedge clk);
      if (div_done) begin
        if (c <= 12) dones++;
        else begin lat = c; res = div_result; end
      end
      if (c == 11) begin
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %b expected 0", div_busy); end
        tests++; if (div_result !== last_result) begin fails++; $display("FAIL flush_result_held: got %h expected %h", div_result, last_result); end
      end
      if (c == 12) begin
        tests++; if (div_stall !== 1'b1) begin fails++; $display("FAIL flush_restart_stall: got %b expected 1", div_stall); end
      end
    end
    div_start = 1'b0;
    tests++; if (dones != 0) begin fails++; $display("FAIL flush_no_done: got %0d expected 0", dones); end
    tests++; if (lat != 46) begin fails++; $display("FAIL flush_restart_latency: got %0d expected 46", lat); end
    tests++; if (res !== 32'd3) begin fails++; $display("FAIL flush_restart_result: got %h expected 3", res); end
    last_result = 32'd3;
    // Flush alongside a start in IDLE: the start must be dropped.
    step();
    div_start = 1'b1; div_flush = 1'b1; div_s1 = 32'd50; div_s2 = 32'd5;
    @(negedge clk);
    tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL flush_vs_start_stall: got %b expected 0", div_stall); end
    step();
    div_start = 1'b0; div_flush = 1'b0;
    @(negedge clk);
    tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL flush_vs_start_busy: got %b expected 0", div_busy); end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int lat = -1;
    logic [31:0] res = 'x;
    step();
    div_start = 1'b1; div_op = 2'b01; div_s1 = 32'd1000; div_s2 = 32'd10;
    for (int c = 1; c <= 60; c++) begin
      step();
      div_start = (c == 5);
      div_s1 = (c == 5) ? 32'd77 : 32'd1000;
      div_s2 = (c == 5) ? 32'd7 : 32'd10;
      @(negedge clk);
      if (div_done) begin dones++; lat = c; res = div_result; end
    end
    tests++; if (dones != 1) begin fails++; $display("FAIL busy_start_done_count: got %0d expected 1", dones); end
    tests++; if (lat != 34) begin fails++; $display("FAIL busy_start_latency: got %0d expected 34", lat); end
    tests++; if (res !== 32'd100) begin fails++; $display("FAIL busy_start_result: got %h expected 100", res); end
    last_result = 32'd100;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2, s1, s2;
    run_op(2'b00, 32'hFFFF_FF9C, 32'd9, r1, l1, s1);
    run_op(2'b11, 32'd123457, 32'd1000, r2, l2, s2);
    tests++; if (r1 !== 32'hFFFF_FFF5) begin fails++; $display("FAIL b2b_first_result: got %h expected fffffff5", r1); end
    tests++; if (r2 !== 32'd457) begin fails++; $display("FAIL b2b_second_result: got %h expected 1c9", r2); end
    tests++; if (l2 != 34) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 34", l2); end
    last_result = r2;
    // Flush during the DONE cycle does not suppress the pulse.
    step();
    div_start = 1'b1; div_op = 2'b11; div_s1 = 32'd50; div_s2 = 32'd8;
    for (int c = 1; c <= 36; c++) begin
      step();
      div_start = 1'b0;
      div_flush = (c == 34);
      @(negedge clk);
      if (c == 34) begin
        tests++; if (div_done !== 1'b1) begin fails++; $display("FAIL done_flush_pulse: got %b expected 1", div_done); end
        tests++; if (div_result !== 32'd2) begin fails++; $display("FAIL done_flush_result: got %h expected 2", div_result); end
      end
      if (c == 35) begin
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL done_flush_idle: got %b expected 0", div_busy); end
      end
    end
    div_flush = 1'b0;
    last_result = 32'd2;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat, stalls;
    step();
    div_start = 1'b1; div_op = 2'b01; div_s1 = 32'd100; div_s2 = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      step();
      div_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b expected 0", div_busy); end
    tests++; if (div_result !== 32'd0) begin fails++; $display("FAIL async_reset_result: got %h expected 0", div_result); end
    tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL async_reset_stall: got %b expected 0", div_stall); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd100, 32'd7, res, lat, stalls);
    tests++; if (res !== 32'd14) begin fails++; $display("FAIL post_reset_result: got %h expected e", res); end
    tests++; if (lat != 34) begin fails++; $display("FAIL post_reset_latency: got %0d expected 34", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
